// File: rtl/hazard_scoreboard.sv
// Issue/retire hazard tracker for scalar registers and the condition code.
// Holds decode on RAW/saturation hazards and holds fetch while a branch resolves.
module hazard_scoreboard #(
    parameter int NUM_RF   = 16,
    parameter int WDOG_MAX = 255
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    input  logic              I_IssueValid,
    input  logic              I_Src1Use,
    input  logic              I_Src2Use,
    input  logic [3:0]        I_Src1Idx,
    input  logic [3:0]        I_Src2Idx,
    input  logic              I_DestWrite,
    input  logic [3:0]        I_DestIdx,
    input  logic              I_CCUse,
    input  logic              I_CCWrite,
    input  logic              I_IsBranch,
    input  logic              I_RetireValid,
    input  logic              I_RetireRegWrite,
    input  logic [3:0]        I_RetireIdx,
    input  logic              I_RetireCCWrite,
    input  logic              I_WriteBackPCEn,
    output logic              O_DepStall,
    output logic              O_BranchStall,
    output logic [NUM_RF-1:0] O_BusyMask,
    output logic              O_CCBusy,
    output logic              O_Error
);

    localparam int IDX_W = 4;
    localparam int WD_W  = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [WD_W-1:0]   wdog, wdog_next;
    logic              wdog_err;
    logic [1:0]        reg_cnt      [NUM_RF];
    logic [1:0]        reg_cnt_next [NUM_RF];
    logic [1:0]        cc_cnt, cc_cnt_next;
    logic [NUM_RF-1:0] reg_inc, reg_dec;
    logic              cc_inc, cc_dec;
    logic              underflow;
    logic              issue_acc;
    logic              src_hazard;

    // An increment and a decrement in the same cycle cancel; otherwise saturate at 3 and floor at 0.
    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic inc,
                                              input logic dec);
        logic [1:0] res;
        res = cnt;
        if (inc && !dec && cnt != 2'd3)
            res = cnt + 2'd1;
        else if (dec && !inc && cnt != 2'd0)
            res = cnt - 2'd1;
        return res;
    endfunction

    function automatic logic cnt_underflow(input logic [1:0] cnt, input logic inc,
                                           input logic dec);
        return dec && !inc && (cnt == 2'd0);
    endfunction

    always_comb begin
        src_hazard = (I_Src1Use && reg_cnt[I_Src1Idx] != 2'd0)
                  || (I_Src2Use && reg_cnt[I_Src2Idx] != 2'd0)
                  || (I_CCUse && cc_cnt != 2'd0)
                  || (I_DestWrite && reg_cnt[I_DestIdx] == 2'd3)
                  || (I_CCWrite && cc_cnt == 2'd3);
        O_DepStall = I_IssueValid && (src_hazard || state == BR_WAIT);
        issue_acc  = I_IssueValid && !O_DepStall;
    end

    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < NUM_RF; i++) begin
            reg_inc[i]      = issue_acc && I_DestWrite && (I_DestIdx == IDX_W'(i));
            reg_dec[i]      = I_RetireValid && I_RetireRegWrite && (I_RetireIdx == IDX_W'(i));
            reg_cnt_next[i] = cnt_update(reg_cnt[i], reg_inc[i], reg_dec[i]);
            underflow       = underflow | cnt_underflow(reg_cnt[i], reg_inc[i], reg_dec[i]);
            O_BusyMask[i]   = (reg_cnt[i] != 2'd0);
        end
        cc_inc      = issue_acc && I_CCWrite;
        cc_dec      = I_RetireValid && I_RetireCCWrite;
        cc_cnt_next = cnt_update(cc_cnt, cc_inc, cc_dec);
        underflow   = underflow | cnt_underflow(cc_cnt, cc_inc, cc_dec);
        O_CCBusy    = (cc_cnt != 2'd0);
    end

    // Branch FSM: a resolved target wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        wdog_next  = wdog;
        wdog_err   = 1'b0;
        case (state)
            IDLE: begin
                if (issue_acc && I_IsBranch) begin
                    state_next = BR_WAIT;
                    wdog_next  = '0;
                end
            end
            BR_WAIT: begin
                wdog_next = wdog + 1'b1;
                if (I_WriteBackPCEn) begin
                    state_next = IDLE;
                end else if (wdog_next == WD_W'(WDOG_MAX)) begin
                    state_next = IDLE;
                    wdog_err   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage boundary: all tracking state registered here.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state   <= IDLE;
            wdog    <= '0;
            cc_cnt  <= '0;
            O_Error <= 1'b0;
            for (int i = 0; i < NUM_RF; i++)
                reg_cnt[i] <= '0;
        end else begin
            state   <= state_next;
            wdog    <= wdog_next;
            cc_cnt  <= cc_cnt_next;
            O_Error <= O_Error | underflow | wdog_err;
            for (int i = 0; i < NUM_RF; i++)
                reg_cnt[i] <= reg_cnt_next[i];
        end
    end

    assign O_BranchStall = (state == BR_WAIT);

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_RF, default 16, number of tracked scalar registers; index width is 4.
REQ-002 Parameter WDOG_MAX, default 255, BR_WAIT watchdog limit in cycles; counter width is 8.
REQ-003 I_CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-004 I_RESET  in  1  synchronous, active-high reset.
REQ-005 I_IssueValid  in  1  decode presents an instruction this cycle.
REQ-006 I_Src1Use / I_Src2Use  in  1 each  source operand 1/2 is read.
REQ-007 I_Src1Idx / I_Src2Idx  in  4 each  source register index.
REQ-008 I_DestWrite  in  1  instruction writes I_DestIdx.
REQ-009 I_DestIdx  in  4  destination register index.
REQ-010 I_CCUse / I_CCWrite  in  1 each  instruction reads / writes the condition code.
REQ-011 I_IsBranch  in  1  instruction is BR*, JMP, JSR or JSRR.
REQ-012 I_RetireValid  in  1  writeback completes an instruction.
REQ-013 I_RetireRegWrite  in  1  the retiring instruction wrote I_RetireIdx.
REQ-014 I_RetireIdx  in  4  retiring destination index.
REQ-015 I_RetireCCWrite  in  1  the retiring instruction wrote CC.
REQ-016 I_WriteBackPCEn  in  1  branch target resolved.
REQ-017 O_DepStall  out  1  combinational; the presented instruction must be held.
REQ-018 O_BranchStall  out  1  registered; fetch must be held.
REQ-019 O_BusyMask  out  16  bit i = (pending count of register i != 0).
REQ-020 O_CCBusy  out  1  CC pending count != 0.
REQ-021 O_Error  out  1  sticky protocol-error flag.

Function
REQ-022 Keep a 2-bit pending counter per scalar register and one for CC, each saturating at 3.
REQ-023 Assert O_DepStall when I_IssueValid and any of these holds: a used source has count != 0; I_CCUse with CC count != 0; I_DestWrite with dest count == 3; I_CCWrite with CC count == 3; FSM is in BR_WAIT.
REQ-024 Compute O_DepStall from registered counters only; a retire in the same cycle does not clear the stall until the next cycle.
REQ-025 Accept an issue when I_IssueValid is high and O_DepStall is low; otherwise the issue has no effect on state.
REQ-026 On an accepted issue, increment the dest count if I_DestWrite, and increment the CC count if I_CCWrite.
REQ-027 On I_RetireValid, decrement the I_RetireIdx count if I_RetireRegWrite, and decrement the CC count if I_RetireCCWrite.
REQ-028 When an accepted issue and a retire hit the same counter in the same cycle, leave that counter unchanged.
REQ-029 A retire decrement of a counter already at 0 leaves it at 0 and sets O_Error.
REQ-030 FSM states are IDLE and BR_WAIT.
REQ-031 IDLE -> BR_WAIT on an accepted issue with I_IsBranch high; clear the watchdog to 0.
REQ-032 In BR_WAIT, increment the watchdog each cycle.
REQ-033 BR_WAIT -> IDLE on I_WriteBackPCEn.
REQ-034 BR_WAIT -> IDLE when the watchdog reaches WDOG_MAX; also set O_Error.
REQ-035 I_WriteBackPCEn in IDLE is ignored and is not an error.
REQ-036 O_BranchStall = 1 exactly while the state is BR_WAIT; it rises on the cycle after the branch issue and falls on the cycle after the release event.
REQ-037 Retires continue to be processed in BR_WAIT.

Reset
REQ-038 While I_RESET is high at a rising edge, all counters become 0, state becomes IDLE, watchdog becomes 0 and O_Error becomes 0.
REQ-039 While I_RESET is high, ignore issue and retire inputs.
REQ-040 The cycle after reset: O_BranchStall=0, O_BusyMask=16'h0000, O_CCBusy=0, O_Error=0.
REQ-041 Reset in BR_WAIT or with counters non-zero discards all pending state; no retire is expected afterwards for pre-reset issues.

Verification
REQ-042 RAW: issue ADD dest R3 -> O_BusyMask=16'h0008. Next cycle present src1=R3 -> O_DepStall=1. Retire R3 -> stall still 1 that cycle, 0 the next, mask=16'h0000.
REQ-043 Saturation: three accepted issues to R5 with no retires -> a 4th issue to R5 gives O_DepStall=1 and the count stays 3. Three retires R5 -> mask bit 5 = 0. A 4th retire R5 -> O_Error=1.
REQ-044 Simultaneous: R2 count=1, then accepted issue dest R2 with retire R2 in the same cycle -> count stays 1, mask bit 2 = 1.
REQ-045 Branch: CMP issues CCWrite -> O_CCBusy=1. BRZ with CCUse stalls until the CMP retire plus 1 cycle. Then BRZ is accepted -> O_BranchStall=1 the next cycle. I_WriteBackPCEn -> O_BranchStall=0 the following cycle.
REQ-046 Watchdog: branch accepted with no I_WriteBackPCEn -> O_BranchStall=1 for 255 cycles, then state IDLE and O_Error=1.
REQ-047 Reset mid-operation: counts R1=2, CC=1, state BR_WAIT, then I_RESET for 1 cycle -> mask=0, CCBusy=0, BranchStall=0, Error=0.
